// File: rtl/computer_pkg.sv
// computer_pkg: shared UART FSM states, 7-segment digit table and baud helper
// for the computer_soc serial display node.
package computer_pkg;

    typedef enum logic [1:0] {S_IDLE, S_START, S_DATA, S_STOP} uart_state_t;

    // Active-low {g,f,e,d,c,b,a}; element n holds the code for digit n.
    localparam logic [9:0][6:0] SEG_TABLE = {
        7'b0010000, 7'b0000000, 7'b1111000, 7'b0000010, 7'b0010010,
        7'b0011001, 7'b0110000, 7'b0100100, 7'b1111001, 7'b1000000
    };

    function automatic int clks_per_bit(input int clock_hz, input int baud_rate);
        return clock_hz / baud_rate;
    endfunction

    function automatic logic [6:0] seg7(input logic [3:0] digit);
        return (digit > 4'd9) ? 7'h7f : SEG_TABLE[digit];
    endfunction

endpackage

// File: rtl/computer_soc_uart_rx.sv
// uart_rx: 8N1 receiver with input synchronizer, mid-bit sampling and a
// one-clock valid pulse for frames whose stop bit is high.
module uart_rx
    import computer_pkg::*;
#(
    parameter int CLKS_PER_BIT = 434
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       rx,
    output logic [7:0] data,
    output logic       valid
);

    localparam int CW = $clog2(CLKS_PER_BIT);
    localparam logic [CW-1:0] LAST = CW'(CLKS_PER_BIT - 1);
    localparam logic [CW-1:0] HALF = CW'(CLKS_PER_BIT / 2 - 1);

    uart_state_t   r_state;
    logic [1:0]    r_sync;
    logic [CW-1:0] r_cnt;
    logic [2:0]    r_bit;
    logic [7:0]    r_shift;
    logic          r_armed;
    logic          w_rx;

    assign w_rx = r_sync[1];

    // r_armed needs the line seen high before a start is accepted, so a stuck-low
    // line or a reset released mid-frame cannot spawn repeated frames.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_sync  <= 2'b00;
            r_state <= S_IDLE;
            r_cnt   <= '0;
            r_bit   <= '0;
            r_shift <= '0;
            r_armed <= 1'b0;
            data    <= '0;
            valid   <= 1'b0;
        end else begin
            r_sync <= {r_sync[0], rx};
            valid  <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    r_cnt   <= '0;
                    r_armed <= r_armed | w_rx;
                    if (!w_rx && r_armed) r_state <= S_START;
                end
                S_START: begin
                    r_cnt <= r_cnt + 1'b1;
                    if (r_cnt == HALF) begin
                        r_cnt   <= '0;
                        r_bit   <= '0;
                        r_state <= w_rx ? S_IDLE : S_DATA;
                    end
                end
                S_DATA: begin
                    r_cnt <= r_cnt + 1'b1;
                    if (r_cnt == LAST) begin
                        r_cnt   <= '0;
                        r_shift <= {w_rx, r_shift[7:1]};
                        r_bit   <= r_bit + 1'b1;
                        if (r_bit == 3'd7) r_state <= S_STOP;
                    end
                end
                S_STOP: begin
                    r_cnt <= r_cnt + 1'b1;
                    if (r_cnt == LAST) begin
                        valid   <= w_rx;
                        r_armed <= w_rx;
                        r_state <= S_IDLE;
                        if (w_rx) data <= r_shift;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: rtl/computer_soc.sv
// computer_soc: UART byte receiver that echoes good bytes on tx and shows the last
// one as three decimal 7-segment digits plus its low nibble on LEDs.
module computer_soc
    import computer_pkg::*;
#(
    parameter int CLOCK_HZ  = 50_000_000,
    parameter int BAUD_RATE = 115200
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       rx,
    output logic       tx,
    output logic [3:0] led_out_data,
    output logic [6:0] seg_out_1,
    output logic [6:0] seg_out_2,
    output logic [6:0] seg_out_3
);

    localparam int CLKS_PER_BIT = clks_per_bit(CLOCK_HZ, BAUD_RATE);
    localparam int CW = $clog2(CLKS_PER_BIT);
    localparam logic [CW-1:0] LAST = CW'(CLKS_PER_BIT - 1);

    logic [7:0]    w_data;
    logic          w_valid;
    logic [7:0]    r_data;
    uart_state_t   r_tx_state;
    logic [CW-1:0] r_tx_cnt;
    logic [2:0]    r_tx_bit;
    logic [7:0]    r_tx_shift;
    logic [7:0]    r_pend;
    logic          r_pend_valid;
    logic          r_tx;
    logic          w_tx_free;
    logic          w_load;
    logic [7:0]    w_load_byte;

    uart_rx #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_rx (
        .clk  (clk),
        .rst  (rst),
        .rx   (rx),
        .data (w_data),
        .valid(w_valid)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_data <= '0;
        else if (w_valid) r_data <= w_data;
    end

    assign led_out_data = r_data[3:0];
    assign seg_out_3    = seg7(4'(r_data / 8'd100));
    assign seg_out_2    = seg7(4'((r_data % 8'd100) / 8'd10));
    assign seg_out_1    = seg7(4'(r_data % 8'd10));

    // The last stop-bit cycle counts as free, so a byte arriving then starts at once.
    assign w_tx_free   = (r_tx_state == S_IDLE) || (r_tx_state == S_STOP && r_tx_cnt == LAST);
    assign w_load      = w_tx_free && (w_valid || r_pend_valid);
    assign w_load_byte = w_valid ? w_data : r_pend;
    assign tx          = r_tx;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_tx_state   <= S_IDLE;
            r_tx_cnt     <= '0;
            r_tx_bit     <= '0;
            r_tx_shift   <= '0;
            r_pend       <= '0;
            r_pend_valid <= 1'b0;
            r_tx         <= 1'b1;
        end else begin
            if (w_valid && !w_tx_free) begin
                r_pend       <= w_data;
                r_pend_valid <= 1'b1;
            end else if (w_load) begin
                r_pend_valid <= 1'b0;
            end
            if (w_load) begin
                r_tx_state <= S_START;
                r_tx_cnt   <= '0;
                r_tx_shift <= w_load_byte;
                r_tx       <= 1'b0;
            end else begin
                case (r_tx_state)
                    S_IDLE: r_tx <= 1'b1;
                    S_START: begin
                        r_tx_cnt <= r_tx_cnt + 1'b1;
                        if (r_tx_cnt == LAST) begin
                            r_tx_cnt   <= '0;
                            r_tx_bit   <= '0;
                            r_tx       <= r_tx_shift[0];
                            r_tx_state <= S_DATA;
                        end
                    end
                    S_DATA: begin
                        r_tx_cnt <= r_tx_cnt + 1'b1;
                        if (r_tx_cnt == LAST) begin
                            r_tx_cnt <= '0;
                            if (r_tx_bit == 3'd7) begin
                                r_tx       <= 1'b1;
                                r_tx_state <= S_STOP;
                            end else begin
                                r_tx_bit   <= r_tx_bit + 1'b1;
                                r_tx_shift <= {1'b0, r_tx_shift[7:1]};
                                r_tx       <= r_tx_shift[1];
                            end
                        end
                    end
                    S_STOP: begin
                        r_tx_cnt <= r_tx_cnt + 1'b1;
                        if (r_tx_cnt == LAST) r_tx_state <= S_IDLE;
                    end
                    default: r_tx_state <= S_IDLE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_computer_soc.sv
// tb_computer_soc: drives 8N1 frames into computer_soc and checks display, LEDs
// and the tx echo against a byte-level model of the node.
module tb_computer_soc;

    localparam int CLOCK_HZ = 11_520_000;
    localparam int BAUD     = 115200;
    localparam int CPB      = CLOCK_HZ / BAUD;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       rx  = 1'b1;
    logic       tx;
    logic [3:0] led;
    logic [6:0] s1, s2, s3;

    int n_cmp = 0;
    int n_err = 0;
    int cyc = 0;
    int n_valid = 0;
    int valid_cyc = 0;
    int tx_fall_cyc = 0;
    int n_tx_fall = 0;
    logic [7:0] mon_b;
    logic [7:0] echo_q[$];
    logic [7:0] exp_q[$];
    logic [7:0] exp_byte = 8'h00;

    computer_soc #(.CLOCK_HZ(CLOCK_HZ), .BAUD_RATE(BAUD)) dut (
        .clk         (clk),
        .rst         (rst),
        .rx          (rx),
        .tx          (tx),
        .led_out_data(led),
        .seg_out_1   (s1),
        .seg_out_2   (s2),
        .seg_out_3   (s3)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc = cyc + 1;

    always @(negedge clk) begin
        if (dut.u_rx.valid === 1'b1) begin
            n_valid++;
            valid_cyc = cyc;
        end
    end

    // Independent UART decoder on tx: samples each bit at its middle.
    initial forever begin
        @(negedge tx);
        n_tx_fall++;
        tx_fall_cyc = cyc;
        repeat (CPB / 2) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            repeat (CPB) @(negedge clk);
            mon_b[i] = tx;
        end
        repeat (CPB) @(negedge clk);
        if (tx === 1'b1) echo_q.push_back(mon_b);
    end

    initial begin
        #5ms;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    function automatic logic [6:0] seg_model(input int d);
        case (d)
            0: return 7'b1000000;
            1: return 7'b1111001;
            2: return 7'b0100100;
            3: return 7'b0110000;
            4: return 7'b0011001;
            5: return 7'b0010010;
            6: return 7'b0000010;
            7: return 7'b1111000;
            8: return 7'b0000000;
            9: return 7'b0010000;
            default: return 7'bxxxxxxx;
        endcase
    endfunction

    function automatic logic [20:0] disp_model(input logic [7:0] b);
        int v;
        v = b;
        return {seg_model(v / 100), seg_model((v / 10) % 10), seg_model(v % 10)};
    endfunction

    task automatic send(input logic [7:0] b, input logic stop_bit);
        rx = 1'b0;
        repeat (CPB) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            rx = b[i];
            repeat (CPB) @(negedge clk);
        end
        rx = stop_bit;
        repeat (CPB) @(negedge clk);
        rx = 1'b1;
        if (stop_bit) begin
            exp_byte = b;
            exp_q.push_back(b);
        end
    endtask

    task automatic drain();
        repeat (12 * CPB) @(negedge clk);
    endtask

    task automatic test_reset();
        repeat (5) @(negedge clk);
        n_cmp++;
        if (tx !== 1'b1) begin
            n_err++;
            $display("FAIL reset_tx_during: got %b want 1", tx);
        end
        rst = 1'b0;
        repeat (3) @(negedge clk);
        n_cmp++;
        if (tx !== 1'b1) begin
            n_err++;
            $display("FAIL reset_tx: got %b want 1", tx);
        end
        n_cmp++;
        if (led !== 4'h0) begin
            n_err++;
            $display("FAIL reset_led: got %h want 0", led);
        end
        n_cmp++;
        if ({s3, s2, s1} !== {3{7'b1000000}}) begin
            n_err++;
            $display("FAIL reset_seg: got %b %b %b want 1000000 x3", s3, s2, s1);
        end
        repeat (2 * CPB) @(negedge clk);
    endtask

    task automatic test_single();
        send(8'hAA, 1'b1);
        n_cmp++;
        if (led !== 4'hA) begin
            n_err++;
            $display("FAIL aa_led: got %h want a", led);
        end
        n_cmp++;
        if ({s3, s2, s1} !== {7'b1111001, 7'b1111000, 7'b1000000}) begin
            n_err++;
            $display("FAIL aa_seg: got %b %b %b want 1111001 1111000 1000000", s3, s2, s1);
        end
        drain();
        n_cmp++;
        if (!(tx_fall_cyc >= valid_cyc && tx_fall_cyc - valid_cyc <= 2)) begin
            n_err++;
            $display("FAIL aa_echo_latency: got %0d cycles want 0..2", tx_fall_cyc - valid_cyc);
        end
        n_cmp++;
        if (echo_q.size() !== exp_q.size()) begin
            n_err++;
            $display("FAIL aa_echo_count: got %0d want %0d", echo_q.size(), exp_q.size());
        end else foreach (exp_q[i]) begin
            n_cmp++;
            if (echo_q[i] !== exp_q[i]) begin
                n_err++;
                $display("FAIL aa_echo[%0d]: got %h want %h", i, echo_q[i], exp_q[i]);
            end
        end
        echo_q.delete();
        exp_q.delete();
    endtask

    task automatic test_repeat();
        int v0;
        v0 = n_valid;
        for (int k = 0; k < 6; k++) begin
            send(8'hAA, 1'b1);
            n_cmp++;
            if ({s3, s2, s1} !== disp_model(exp_byte)) begin
                n_err++;
                $display("FAIL repeat_seg[%0d]: got %b %b %b want 170", k, s3, s2, s1);
            end
            repeat (100) @(negedge clk);
        end
        drain();
        n_cmp++;
        if (n_valid - v0 !== 6) begin
            n_err++;
            $display("FAIL repeat_valid_count: got %0d want 6", n_valid - v0);
        end
        n_cmp++;
        if (echo_q.size() !== exp_q.size()) begin
            n_err++;
            $display("FAIL repeat_echo_count: got %0d want %0d", echo_q.size(), exp_q.size());
        end else foreach (exp_q[i]) begin
            n_cmp++;
            if (echo_q[i] !== exp_q[i]) begin
                n_err++;
                $display("FAIL repeat_echo[%0d]: got %h want %h", i, echo_q[i], exp_q[i]);
            end
        end
        echo_q.delete();
        exp_q.delete();
    endtask

    task automatic test_back_to_back();
        send(8'hFF, 1'b1);
        n_cmp++;
        if ({s3, s2, s1} !== disp_model(8'd255)) begin
            n_err++;
            $display("FAIL b2b_seg_255: got %b %b %b want 255", s3, s2, s1);
        end
        send(8'h00, 1'b1);
        n_cmp++;
        if ({led, s3, s2, s1} !== {4'h0, disp_model(8'd0)}) begin
            n_err++;
            $display("FAIL b2b_seg_000: got led %h seg %b %b %b want 0 000", led, s3, s2, s1);
        end
        drain();
        n_cmp++;
        if (echo_q.size() !== exp_q.size()) begin
            n_err++;
            $display("FAIL b2b_echo_count: got %0d want %0d", echo_q.size(), exp_q.size());
        end else foreach (exp_q[i]) begin
            n_cmp++;
            if (echo_q[i] !== exp_q[i]) begin
                n_err++;
                $display("FAIL b2b_echo[%0d]: got %h want %h", i, echo_q[i], exp_q[i]);
            end
        end
        echo_q.delete();
        exp_q.delete();
    endtask

    task automatic test_framing_error();
        int v0, f0;
        v0 = n_valid;
        f0 = n_tx_fall;
        send(8'h55, 1'b0);
        repeat (3 * CPB) @(negedge clk);
        n_cmp++;
        if (n_valid !== v0) begin
            n_err++;
            $display("FAIL ferr_valid: got %0d pulses want 0", n_valid - v0);
        end
        n_cmp++;
        if ({led, s3, s2, s1} !== {exp_byte[3:0], disp_model(exp_byte)}) begin
            n_err++;
            $display("FAIL ferr_display: got led %h seg %b %b %b want byte %h", led, s3, s2, s1, exp_byte);
        end
        n_cmp++;
        if (n_tx_fall !== f0 || tx !== 1'b1) begin
            n_err++;
            $display("FAIL ferr_tx: got %0d starts tx=%b want 0 starts tx=1", n_tx_fall - f0, tx);
        end
    endtask

    task automatic test_held_low();
        int v0, f0;
        v0 = n_valid;
        f0 = n_tx_fall;
        rx = 1'b0;
        repeat (25 * CPB) @(negedge clk);
        n_cmp++;
        if (n_valid !== v0 || n_tx_fall !== f0) begin
            n_err++;
            $display("FAIL held_low: got %0d pulses %0d tx starts want 0 0", n_valid - v0, n_tx_fall - f0);
        end
        rx = 1'b1;
        repeat (2 * CPB) @(negedge clk);
        rx = 1'b0;
        repeat (10) @(negedge clk);
        rx = 1'b1;
        repeat (2 * CPB) @(negedge clk);
        n_cmp++;
        if (n_valid !== v0) begin
            n_err++;
            $display("FAIL glitch_valid: got %0d pulses want 0", n_valid - v0);
        end
        send(8'h3C, 1'b1);
        n_cmp++;
        if ({led, s3, s2, s1} !== {4'hC, disp_model(8'd60)}) begin
            n_err++;
            $display("FAIL held_low_recover: got led %h seg %b %b %b want c 060", led, s3, s2, s1);
        end
        drain();
        echo_q.delete();
        exp_q.delete();
    endtask

    task automatic test_reset_midframe();
        logic [7:0] b;
        int v0;
        b = 8'h0F;
        send(8'h99, 1'b1);
        rx = 1'b0;
        repeat (CPB) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            rx = b[i];
            if (i == 5) begin
                repeat (CPB / 2) @(negedge clk);
                rst = 1'b1;
                @(negedge clk);
                n_cmp++;
                if (tx !== 1'b1) begin
                    n_err++;
                    $display("FAIL midrst_tx: got %b want 1", tx);
                end
                repeat (2) @(negedge clk);
                rst = 1'b0;
                exp_byte = 8'h00;
                v0 = n_valid;
                n_cmp++;
                if ({tx, led, s3, s2, s1} !== {1'b1, 4'h0, {3{7'b1000000}}}) begin
                    n_err++;
                    $display("FAIL midrst_outputs: got tx %b led %h seg %b %b %b want reset values", tx, led, s3, s2, s1);
                end
                repeat (CPB - CPB / 2 - 3) @(negedge clk);
            end else begin
                repeat (CPB) @(negedge clk);
            end
        end
        rx = 1'b1;
        repeat (3 * CPB) @(negedge clk);
        n_cmp++;
        if (n_valid !== v0) begin
            n_err++;
            $display("FAIL midrst_stale_frame: got %0d pulses want 0", n_valid - v0);
        end
        echo_q.delete();
        exp_q.delete();
        send(8'h07, 1'b1);
        n_cmp++;
        if ({led, s3, s2, s1} !== {4'h7, 7'b1000000, 7'b1000000, 7'b1111000}) begin
            n_err++;
            $display("FAIL midrst_007: got led %h seg %b %b %b want 7 007", led, s3, s2, s1);
        end
        drain();
        n_cmp++;
        if (echo_q.size() !== 1 || echo_q[0] !== 8'h07) begin
            n_err++;
            $display("FAIL midrst_echo: got %0d bytes first %h want 1 byte 07", echo_q.size(), echo_q.size() > 0 ? echo_q[0] : 8'hxx);
        end
        echo_q.delete();
        exp_q.delete();
    endtask

    task automatic test_random();
        int v0, n_good;
        logic [7:0] b;
        logic stop_bit;
        v0 = n_valid;
        n_good = 0;
        for (int k = 0; k < 10; k++) begin
            b = 8'($urandom);
            stop_bit = ($urandom_range(0, 4) != 0);
            send(b, stop_bit);
            if (stop_bit) n_good++;
            n_cmp++;
            if ({led, s3, s2, s1} !== {exp_byte[3:0], disp_model(exp_byte)}) begin
                n_err++;
                $display("FAIL rand_display[%0d]: got led %h seg %b %b %b want byte %h", k, led, s3, s2, s1, exp_byte);
            end
            repeat ($urandom_range(0, 200)) @(negedge clk);
        end
        drain();
        n_cmp++;
        if (n_valid - v0 !== n_good) begin
            n_err++;
            $display("FAIL rand_valid_count: got %0d want %0d", n_valid - v0, n_good);
        end
        n_cmp++;
        if (echo_q.size() !== exp_q.size()) begin
            n_err++;
            $display("FAIL rand_echo_count: got %0d want %0d", echo_q.size(), exp_q.size());
        end else foreach (exp_q[i]) begin
            n_cmp++;
            if (echo_q[i] !== exp_q[i]) begin
                n_err++;
                $display("FAIL rand_echo[%0d]: got %h want %h", i, echo_q[i], exp_q[i]);
            end
        end
        echo_q.delete();
        exp_q.delete();
    endtask

    initial begin
        test_reset();
        test_single();
        test_repeat();
        test_back_to_back();
        test_framing_error();
        test_held_low();
        test_reset_midframe();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
